writeback_commit_unit_l4: RTL and testbench

Multi-pipe, multi-commit reordering writeback-commit unit with register renaming. It accepts completed instructions from `p_num_pipes` execute pipes and arbitrates them round-robin, one per cycle. Each accepted instruction is broadcast on a completion notification and parked in a reorder buffer indexed by sequence number. Up to `p_commit_width` consecutive instructions then retire in program order per cycle. It sits between the X pipes and the rename/free-list and architectural-state consumers, replacing the single-commit L3 unit.

---
 rtl/writeback_commit_unit_l4.sv | 194 +++++++++++++++++++
 tb/tb_writeback_commit_unit_l4.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_commit_unit_l4.sv
// Reordering writeback-commit unit: round-robin accept from N pipes into a seq_num-indexed ROB,
// in-order retirement of up to p_commit_width entries per cycle. Option: WCU_L4_REG_COMMIT_EN registers commit lanes.
module writeback_commit_unit_l4 #(
  parameter int p_num_pipes      = 2,
  parameter int p_seq_num_bits   = 3,
  parameter int p_phys_addr_bits = 6,
  parameter int p_commit_width   = 2
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [p_num_pipes-1:0]                           ex_val_i,
  output logic [p_num_pipes-1:0]                           ex_rdy_o,
  input  logic [p_num_pipes-1:0][31:0]                     ex_pc_i,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]       ex_seq_num_i,
  input  logic [p_num_pipes-1:0][4:0]                      ex_waddr_i,
  input  logic [p_num_pipes-1:0][31:0]                     ex_wdata_i,
  input  logic [p_num_pipes-1:0]                           ex_wen_i,
  input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]     ex_preg_i,
  input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]     ex_ppreg_i,
  output logic                                             complete_val_o,
  output logic [p_seq_num_bits-1:0]                        complete_seq_num_o,
  output logic [4:0]                                       complete_waddr_o,
  output logic [31:0]                                      complete_wdata_o,
  output logic                                             complete_wen_o,
  output logic [p_phys_addr_bits-1:0]                      complete_preg_o,
  output logic [p_commit_width-1:0]                        commit_val_o,
  output logic [p_commit_width-1:0][31:0]                  commit_pc_o,
  output logic [p_commit_width-1:0][p_seq_num_bits-1:0]    commit_seq_num_o,
  output logic [p_commit_width-1:0][4:0]                   commit_waddr_o,
  output logic [p_commit_width-1:0][31:0]                  commit_wdata_o,
  output logic [p_commit_width-1:0]                        commit_wen_o,
  output logic [p_commit_width-1:0][p_phys_addr_bits-1:0]  commit_ppreg_o
);
  localparam int DEPTH  = 1 << p_seq_num_bits;
  localparam int PIDX_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  logic [DEPTH-1:0]            rob_vld_q, rob_vld_d;
  logic [31:0]                 rob_pc_q    [DEPTH];
  logic [4:0]                  rob_waddr_q [DEPTH];
  logic [31:0]                 rob_wdata_q [DEPTH];
  logic                        rob_wen_q   [DEPTH];
  logic [p_phys_addr_bits-1:0] rob_ppreg_q [DEPTH];
  logic [p_seq_num_bits-1:0]   head_q, head_d;
  logic [PIDX_W-1:0]           rr_q, rr_d;

  logic                        cmp_val_q;
  logic [p_seq_num_bits-1:0]   cmp_seq_q;
  logic [4:0]                  cmp_waddr_q;
  logic [31:0]                 cmp_wdata_q;
  logic                        cmp_wen_q;
  logic [p_phys_addr_bits-1:0] cmp_preg_q;

  logic [p_num_pipes-1:0]      elig;
  logic                        grant_vld;
  logic [PIDX_W-1:0]           grant_idx;
  logic [p_seq_num_bits-1:0]   wr_idx;

  logic [p_commit_width-1:0]                        lane_vld;
  logic [p_commit_width-1:0][p_seq_num_bits-1:0]    lane_idx;
  logic [p_commit_width-1:0][31:0]                  lane_pc;
  logic [p_commit_width-1:0][4:0]                   lane_waddr;
  logic [p_commit_width-1:0][31:0]                  lane_wdata;
  logic [p_commit_width-1:0]                        lane_wen;
  logic [p_commit_width-1:0][p_phys_addr_bits-1:0]  lane_ppreg;

  // An occupied ROB slot means the request aliases an older instruction; hold it off.
  always_comb begin
    int cand;
    cand      = 0;
    elig      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < p_num_pipes; i++)
      elig[i] = ex_val_i[i] && !rob_vld_q[ex_seq_num_i[i]];
    for (int o = 0; o < p_num_pipes; o++) begin
      cand = (int'(rr_q) + o) % p_num_pipes;
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = PIDX_W'(cand);
      end
    end
    ex_rdy_o = '0;
    if (grant_vld && !rst)
      ex_rdy_o[grant_idx] = 1'b1;
    wr_idx = ex_seq_num_i[grant_idx];
    rr_d   = grant_vld ? PIDX_W'((int'(grant_idx) + 1) % p_num_pipes) : rr_q;
  end

  // Lanes stay contiguous: the first invalid entry stops every lane above it.
  always_comb begin
    logic run;
    int   n_commit;
    run      = 1'b1;
    n_commit = 0;
    for (int k = 0; k < p_commit_width; k++) begin
      lane_idx[k]   = head_q + p_seq_num_bits'(k);
      run           = run && rob_vld_q[lane_idx[k]];
      lane_vld[k]   = run;
      lane_pc[k]    = rob_pc_q[lane_idx[k]];
      lane_waddr[k] = rob_waddr_q[lane_idx[k]];
      lane_wdata[k] = rob_wdata_q[lane_idx[k]];
      lane_wen[k]   = rob_wen_q[lane_idx[k]];
      lane_ppreg[k] = rob_ppreg_q[lane_idx[k]];
      if (run)
        n_commit = n_commit + 1;
    end
    head_d    = head_q + p_seq_num_bits'(n_commit);
    rob_vld_d = rob_vld_q;
    for (int k = 0; k < p_commit_width; k++)
      if (lane_vld[k])
        rob_vld_d[lane_idx[k]] = 1'b0;
    if (grant_vld)
      rob_vld_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rob_vld_q   <= '0;
      head_q      <= '0;
      rr_q        <= '0;
      cmp_val_q   <= 1'b0;
      cmp_seq_q   <= '0;
      cmp_waddr_q <= '0;
      cmp_wdata_q <= '0;
      cmp_wen_q   <= 1'b0;
      cmp_preg_q  <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        rob_pc_q[d]    <= '0;
        rob_waddr_q[d] <= '0;
        rob_wdata_q[d] <= '0;
        rob_wen_q[d]   <= 1'b0;
        rob_ppreg_q[d] <= '0;
      end
    end else begin
      rob_vld_q <= rob_vld_d;
      head_q    <= head_d;
      rr_q      <= rr_d;
      cmp_val_q <= grant_vld;
      if (grant_vld) begin
        rob_pc_q[wr_idx]    <= ex_pc_i[grant_idx];
        rob_waddr_q[wr_idx] <= ex_waddr_i[grant_idx];
        rob_wdata_q[wr_idx] <= ex_wdata_i[grant_idx];
        rob_wen_q[wr_idx]   <= ex_wen_i[grant_idx];
        rob_ppreg_q[wr_idx] <= ex_ppreg_i[grant_idx];
        cmp_seq_q           <= wr_idx;
        cmp_waddr_q         <= ex_waddr_i[grant_idx];
        cmp_wdata_q         <= ex_wdata_i[grant_idx];
        cmp_wen_q           <= ex_wen_i[grant_idx];
        cmp_preg_q          <= ex_preg_i[grant_idx];
      end
    end
  end

  assign complete_val_o     = cmp_val_q;
  assign complete_seq_num_o = cmp_seq_q;
  assign complete_waddr_o   = cmp_waddr_q;
  assign complete_wdata_o   = cmp_wdata_q;
  assign complete_wen_o     = cmp_wen_q;
  assign complete_preg_o    = cmp_preg_q;

`ifdef WCU_L4_REG_COMMIT_EN
  // Entries retire on the capture edge, so each lane is presented exactly once, a cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_val_o     <= '0;
      commit_pc_o      <= '0;
      commit_seq_num_o <= '0;
      commit_waddr_o   <= '0;
      commit_wdata_o   <= '0;
      commit_wen_o     <= '0;
      commit_ppreg_o   <= '0;
    end else begin
      commit_val_o     <= lane_vld;
      commit_pc_o      <= lane_pc;
      commit_seq_num_o <= lane_idx;
      commit_waddr_o   <= lane_waddr;
      commit_wdata_o   <= lane_wdata;
      commit_wen_o     <= lane_wen;
      commit_ppreg_o   <= lane_ppreg;
    end
  end
`else
  always_comb begin
    commit_val_o     = lane_vld;
    commit_pc_o      = lane_pc;
    commit_seq_num_o = lane_idx;
    commit_waddr_o   = lane_waddr;
    commit_wdata_o   = lane_wdata;
    commit_wen_o     = lane_wen;
    commit_ppreg_o   = lane_ppreg;
  end
`endif

endmodule

// File: tb/tb_writeback_commit_unit_l4.sv
// Directed bench for writeback_commit_unit_l4 (2 pipes, 8-entry ROB, 2 commit lanes).
module tb_writeback_commit_unit_l4;
  localparam int NP = 2, SB = 3, PB = 6, CW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]          ex_val, ex_rdy, ex_wen;
  logic [NP-1:0][31:0]    ex_pc, ex_wdata;
  logic [NP-1:0][SB-1:0]  ex_seq;
  logic [NP-1:0][4:0]     ex_waddr;
  logic [NP-1:0][PB-1:0]  ex_preg, ex_ppreg;

  logic          cmp_val, cmp_wen;
  logic [SB-1:0] cmp_seq;
  logic [4:0]    cmp_waddr;
  logic [31:0]   cmp_wdata;
  logic [PB-1:0] cmp_preg;

  logic [CW-1:0]          com_val, com_wen;
  logic [CW-1:0][31:0]    com_pc, com_wdata;
  logic [CW-1:0][SB-1:0]  com_seq;
  logic [CW-1:0][4:0]     com_waddr;
  logic [CW-1:0][PB-1:0]  com_ppreg;

  int total = 0;
  int bad   = 0;

  writeback_commit_unit_l4 #(
    .p_num_pipes(NP), .p_seq_num_bits(SB), .p_phys_addr_bits(PB), .p_commit_width(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_val_i(ex_val), .ex_rdy_o(ex_rdy), .ex_pc_i(ex_pc), .ex_seq_num_i(ex_seq),
    .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_wen_i(ex_wen),
    .ex_preg_i(ex_preg), .ex_ppreg_i(ex_ppreg),
    .complete_val_o(cmp_val), .complete_seq_num_o(cmp_seq), .complete_waddr_o(cmp_waddr),
    .complete_wdata_o(cmp_wdata), .complete_wen_o(cmp_wen), .complete_preg_o(cmp_preg),
    .commit_val_o(com_val), .commit_pc_o(com_pc), .commit_seq_num_o(com_seq),
    .commit_waddr_o(com_waddr), .commit_wdata_o(com_wdata), .commit_wen_o(com_wen),
    .commit_ppreg_o(com_ppreg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input int seq, input logic [31:0] pc, input logic [4:0] wa,
                       input logic [31:0] wd, input logic wen, input logic [PB-1:0] preg,
                       input logic [PB-1:0] ppreg);
    ex_val[p]   = 1'b1;
    ex_seq[p]   = SB'(seq);
    ex_pc[p]    = pc;
    ex_waddr[p] = wa;
    ex_wdata[p] = wd;
    ex_wen[p]   = wen;
    ex_preg[p]  = preg;
    ex_ppreg[p] = ppreg;
  endtask

  task automatic idle();
    ex_val = '0;
  endtask

  task automatic reset_dut();
    ex_val = '0;
    rst    = 1'b1;
    #2;
    rst    = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    ex_val = '0; ex_wen = '0; ex_pc = '0; ex_wdata = '0;
    ex_seq = '0; ex_waddr = '0; ex_preg = '0; ex_ppreg = '0;
    drive(0, 0, 32'h200, 5'd1, 32'hA, 1'b1, 6'd5, 6'd1);
    #3;
    chk("rst_rdy", ex_rdy, 2'b00);
    chk("rst_cmp_val", cmp_val, 1'b0);
    chk("rst_com_val", com_val, 2'b00);
    chk("rst_cmp_wdata", cmp_wdata, 32'h0);
    chk("rst_com_pc0", com_pc[0], 32'h0);
    idle();
    #5;
    rst = 1'b0;
    tick();

`ifdef WCU_L4_REG_COMMIT_EN
    // Reorder with registered commit lanes
    drive(0, 1, 32'h304, 5'd4, 32'h11, 1'b1, 6'd9, 6'd3);
    tick();
    chk("reg_cmp1_seq", cmp_seq, 3'd1);
    chk("reg_cmp1_noc", com_val, 2'b00);
    drive(0, 0, 32'h300, 5'd5, 32'h22, 1'b1, 6'd8, 6'd2);
    tick();
    chk("reg_cmp0_val", cmp_val, 1'b1);
    chk("reg_cmp0_seq", cmp_seq, 3'd0);
    chk("reg_not_yet", com_val, 2'b00);
    idle();
    tick();
    chk("reg_com_val", com_val, 2'b11);
    chk("reg_com_seq0", com_seq[0], 3'd0);
    chk("reg_com_seq1", com_seq[1], 3'd1);
    chk("reg_com_pc1", com_pc[1], 32'h304);
    chk("reg_cmp_idle", cmp_val, 1'b0);
    tick();
    chk("reg_no_dup", com_val, 2'b00);
    drive(0, 2, 32'h308, 5'd6, 32'h33, 1'b1, 6'd10, 6'd4);
    tick();
    chk("reg_s2_wait", com_val, 2'b00);
    idle();
    tick();
    chk("reg_s2_val", com_val, 2'b01);
    chk("reg_s2_seq", com_seq[0], 3'd2);
    tick();
    chk("reg_s2_once", com_val, 2'b00);
`else
    // In-order single pipe
    drive(0, 0, 32'h200, 5'd1, 32'hA, 1'b1, 6'd5, 6'd1);
    #1 chk("s1_rdy0", ex_rdy, 2'b01);
    tick();
    chk("s1_cmp0_val", cmp_val, 1'b1);
    chk("s1_cmp0_seq", cmp_seq, 3'd0);
    chk("s1_cmp0_preg", cmp_preg, 6'd5);
    chk("s1_com0_val", com_val, 2'b01);
    chk("s1_com0_seq", com_seq[0], 3'd0);
    chk("s1_com0_pc", com_pc[0], 32'h200);
    chk("s1_com0_ppreg", com_ppreg[0], 6'd1);
    drive(0, 1, 32'h204, 5'd2, 32'hB, 1'b1, 6'd6, 6'd2);
    #1 chk("s1_rdy1", ex_rdy, 2'b01);
    tick();
    chk("s1_cmp1_seq", cmp_seq, 3'd1);
    chk("s1_com1_val", com_val, 2'b01);
    chk("s1_com1_seq", com_seq[0], 3'd1);
    chk("s1_com1_wdata", com_wdata[0], 32'hB);
    drive(0, 2, 32'h208, 5'd3, 32'hC, 1'b1, 6'd7, 6'd3);
    tick();
    chk("s1_cmp2_seq", cmp_seq, 3'd2);
    chk("s1_cmp2_waddr", cmp_waddr, 5'd3);
    chk("s1_com2_seq", com_seq[0], 3'd2);
    chk("s1_com2_wdata", com_wdata[0], 32'hC);
    idle();
    tick();
    chk("s1_idle_cmp", cmp_val, 1'b0);
    chk("s1_idle_com", com_val, 2'b00);

    // Reorder and dual commit
    reset_dut();
    drive(0, 1, 32'h304, 5'd4, 32'h11, 1'b1, 6'd9, 6'd3);
    #1 chk("s2_rdy", ex_rdy, 2'b01);
    tick();
    chk("s2_cmp1_seq", cmp_seq, 3'd1);
    chk("s2_hold", com_val, 2'b00);
    drive(0, 0, 32'h300, 5'd5, 32'h22, 1'b1, 6'd8, 6'd2);
    tick();
    chk("s2_cmp0_seq", cmp_seq, 3'd0);
    chk("s2_dual_val", com_val, 2'b11);
    chk("s2_dual_seq0", com_seq[0], 3'd0);
    chk("s2_dual_seq1", com_seq[1], 3'd1);
    chk("s2_dual_pc1", com_pc[1], 32'h304);
    chk("s2_dual_wdata0", com_wdata[0], 32'h22);
    idle();
    tick();
    chk("s2_drained", com_val, 2'b00);
    drive(0, 2, 32'h308, 5'd6, 32'h33, 1'b1, 6'd10, 6'd4);
    tick();
    chk("s2_head2_val", com_val, 2'b01);
    chk("s2_head2_seq", com_seq[0], 3'd2);
    idle();
    tick();

    // Round-robin arbitration
    reset_dut();
    drive(0, 0, 32'h10, 5'd1, 32'h1, 1'b1, 6'd1, 6'd1);
    drive(1, 1, 32'h14, 5'd2, 32'h2, 1'b1, 6'd2, 6'd2);
    #1 chk("s3_grant0", ex_rdy, 2'b01);
    tick();
    chk("s3_cmp0", cmp_seq, 3'd0);
    chk("s3_com0", com_seq[0], 3'd0);
    drive(0, 2, 32'h18, 5'd3, 32'h3, 1'b1, 6'd3, 6'd3);
    #1 chk("s3_grant1", ex_rdy, 2'b10);
    tick();
    chk("s3_cmp1", cmp_seq, 3'd1);
    chk("s3_com1_val", com_val, 2'b01);
    chk("s3_com1", com_seq[0], 3'd1);
    drive(1, 3, 32'h1C, 5'd4, 32'h4, 1'b1, 6'd4, 6'd4);
    #1 chk("s3_grant2", ex_rdy, 2'b01);
    tick();
    chk("s3_cmp2", cmp_seq, 3'd2);
    chk("s3_com2", com_seq[0], 3'd2);
    ex_val[0] = 1'b0;
    #1 chk("s3_grant3", ex_rdy, 2'b10);
    tick();
    chk("s3_cmp3", cmp_seq, 3'd3);
    chk("s3_com3", com_seq[0], 3'd3);
    idle();
    tick();

    // Wrap and aliasing: bring head to 7, then fill the ROB with head's entry last
    for (int s = 4; s <= 6; s++) begin
      drive(0, s, 32'h40 + 32'(s), 5'(s), 32'h40 + 32'(s), 1'b1, PB'(s), PB'(s));
      tick();
      chk("s4_pre_seq", com_seq[0], 64'(s));
    end
    idle();
    tick();
    for (int s = 6; s >= 0; s--) begin
      drive(0, s, 32'h400 + 32'(4 * s), 5'(s), 32'h100 + 32'(s), 1'b1, PB'(s), PB'(s));
      tick();
      chk("s4_fill_hold", com_val, 2'b00);
    end
    drive(0, 7, 32'h41C, 5'd7, 32'h107, 1'b1, 6'd7, 6'd7);
    drive(1, 0, 32'h500, 5'd8, 32'h999, 1'b1, 6'd12, 6'd12);
    #1 chk("s4_alias_blk", ex_rdy, 2'b01);
    tick();
    chk("s4_cmp7", cmp_seq, 3'd7);
    chk("s4_wrap_val", com_val, 2'b11);
    chk("s4_wrap_seq0", com_seq[0], 3'd7);
    chk("s4_wrap_seq1", com_seq[1], 3'd0);
    chk("s4_wrap_wdata1", com_wdata[1], 32'h100);
    ex_val[0] = 1'b0;
    #1 chk("s4_full_rdy", ex_rdy, 2'b00);
    tick();
    chk("s4_c12_val", com_val, 2'b11);
    chk("s4_c12_seq0", com_seq[0], 3'd1);
    chk("s4_c12_seq1", com_seq[1], 3'd2);
    chk("s4_alias_rdy", ex_rdy, 2'b10);
    tick();
    chk("s4_alias_cmp", cmp_seq, 3'd0);
    chk("s4_alias_wdata", cmp_wdata, 32'h999);
    chk("s4_c34_seq0", com_seq[0], 3'd3);
    chk("s4_c34_seq1", com_seq[1], 3'd4);
    idle();
    tick();
    chk("s4_c56_seq0", com_seq[0], 3'd5);
    chk("s4_c56_seq1", com_seq[1], 3'd6);
    tick();
    chk("s4_wait7", com_val, 2'b00);
    drive(0, 7, 32'h600, 5'd7, 32'h777, 1'b1, 6'd7, 6'd7);
    #1 chk("s4_rdy7", ex_rdy, 2'b01);
    tick();
    chk("s4_gen2_val", com_val, 2'b11);
    chk("s4_gen2_seq1", com_seq[1], 3'd0);
    chk("s4_gen2_wdata0", com_wdata[0], 32'h777);
    chk("s4_gen2_wdata1", com_wdata[1], 32'h999);
    idle();
    tick();
    chk("s4_empty", com_val, 2'b00);

    // wen=0 passthrough and reset while an entry is pending
    reset_dut();
    drive(0, 0, 32'h700, 5'd9, 32'h55, 1'b0, 6'd3, 6'd4);
    tick();
    chk("s5_cmp_wen", cmp_wen, 1'b0);
    chk("s5_com_val", com_val, 2'b01);
    chk("s5_com_wen", com_wen[0], 1'b0);
    chk("s5_com_waddr", com_waddr[0], 5'd9);
    chk("s5_com_ppreg", com_ppreg[0], 6'd4);
    idle();
    tick();
    drive(0, 2, 32'h708, 5'd10, 32'h66, 1'b1, 6'd5, 6'd6);
    tick();
    chk("s5_pend_cmp", cmp_seq, 3'd2);
    chk("s5_pend_hold", com_val, 2'b00);
    drive(0, 1, 32'h704, 5'd11, 32'h99, 1'b1, 6'd1, 6'd1);
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_rdy", ex_rdy, 2'b00);
    chk("s5_rst_cmp", cmp_val, 1'b0);
    chk("s5_rst_com", com_val, 2'b00);
    idle();
    #1 rst = 1'b0;
    tick();
    chk("s5_post_rst", com_val, 2'b00);
    drive(0, 0, 32'h800, 5'd11, 32'h77, 1'b1, 6'd2, 6'd3);
    tick();
    chk("s5_fresh_val", com_val, 2'b01);
    chk("s5_fresh_wen", com_wen[0], 1'b1);
    chk("s5_fresh_wdata", com_wdata[0], 32'h77);
    drive(0, 1, 32'h804, 5'd12, 32'h88, 1'b1, 6'd4, 6'd5);
    tick();
    chk("s5_no_stale_seq2", com_val, 2'b01);
    chk("s5_seq1", com_seq[0], 3'd1);
    idle();
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
